// File: rtl/alm_div_pipe_if.sv
// Valid/ready stream bundle for alm_div_pipe: operand pair in, Q16.16 quotient and
// divide-by-zero flag out.
interface alm_div_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dz
  );
endinterface

// File: rtl/alm_div_pipe.sv
// 3-stage Mitchell log-domain signed 16-bit divider producing a saturating Q16.16 quotient.
// Define ALM_DIV_EXACT_ABS_EN for exact two's-complement operand magnitudes.
module alm_div_pipe (
  input  logic          clk,
  input  logic          rst_n,
  alm_div_pipe_if.slave io_bus
);

  function automatic logic [15:0] magnitude(input logic [15:0] x);
`ifdef ALM_DIV_EXACT_ABS_EN
    return x[15] ? (16'd0 - x) : x;
`else
    logic [15:0] m;
    m = x ^ {16{x[15]}};
    // -1 collapses to 0 under ones'-complement; keep it a real operand of magnitude 1
    return (x[15] && (m == 16'd0)) ? 16'd1 : m;
`endif
  endfunction

  function automatic logic [3:0] lod(input logic [15:0] x);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) k = 4'(i);
    end
    return k;
  endfunction

  // Leading one is shifted out past bit 14, leaving only the fraction bits
  function automatic logic [14:0] frac(input logic [15:0] x, input logic [3:0] k);
    logic [14:0] f;
    f = x[14:0] << (4'd15 - k);
    return f;
  endfunction

  logic        w_adv;
  logic [15:0] w_mag_a, w_mag_b;
  logic [3:0]  w_ka, w_kb;
  logic [19:0] w_l;
  logic [5:0]  w_sh, w_rsh;
  logic [32:0] w_m_ext, w_mag;
  logic [31:0] w_q;

  logic        r1_valid, r1_sign, r1_dz, r1_zero, r1_aneg;
  logic [3:0]  r1_ka, r1_kb;
  logic [14:0] r1_fa, r1_fb;
  logic        r2_valid, r2_sign, r2_dz, r2_zero, r2_aneg;
  logic [4:0]  r2_kq;
  logic [14:0] r2_fq;
  logic        r_out_valid, r_dz;
  logic [31:0] r_q;

  assign w_adv            = ~r_out_valid | io_bus.out_ready;
  assign io_bus.in_ready  = w_adv;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.q         = r_q;
  assign io_bus.dz        = r_dz;

  assign w_mag_a = magnitude(io_bus.a);
  assign w_mag_b = magnitude(io_bus.b);
  assign w_ka    = lod(w_mag_a);
  assign w_kb    = lod(w_mag_b);

  assign w_l     = {1'b0, r1_ka, r1_fa} - {1'b0, r1_kb, r1_fb};

  // Antilog shift amount is kq+1; a negative amount means shift right
  assign w_sh    = {r2_kq[4], r2_kq} + 6'd1;
  assign w_rsh   = 6'd0 - w_sh;
  assign w_m_ext = {17'd0, 1'b1, r2_fq};
  assign w_mag   = w_sh[5] ? (w_m_ext >> w_rsh) : (w_m_ext << w_sh[4:0]);

  always_comb begin
    w_q = w_mag[31:0];
    if (r2_dz) begin
      w_q = r2_aneg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (r2_zero) begin
      w_q = 32'd0;
    end else if (r2_sign) begin
      w_q = (w_mag > 33'h0_8000_0000) ? 32'h8000_0000 : (32'd0 - w_mag[31:0]);
    end else if (w_mag[32:31] != 2'b00) begin
      w_q = 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_sign     <= 1'b0;
      r1_dz       <= 1'b0;
      r1_zero     <= 1'b0;
      r1_aneg     <= 1'b0;
      r1_ka       <= 4'd0;
      r1_kb       <= 4'd0;
      r1_fa       <= 15'd0;
      r1_fb       <= 15'd0;
      r2_valid    <= 1'b0;
      r2_sign     <= 1'b0;
      r2_dz       <= 1'b0;
      r2_zero     <= 1'b0;
      r2_aneg     <= 1'b0;
      r2_kq       <= 5'd0;
      r2_fq       <= 15'd0;
      r_out_valid <= 1'b0;
      r_q         <= 32'd0;
      r_dz        <= 1'b0;
    end else if (w_adv) begin
      r1_valid    <= io_bus.in_valid;
      r1_sign     <= io_bus.a[15] ^ io_bus.b[15];
      r1_dz       <= (io_bus.b == 16'd0);
      r1_zero     <= (io_bus.a == 16'd0);
      r1_aneg     <= io_bus.a[15];
      r1_ka       <= w_ka;
      r1_kb       <= w_kb;
      r1_fa       <= frac(w_mag_a, w_ka);
      r1_fb       <= frac(w_mag_b, w_kb);
      r2_valid    <= r1_valid;
      r2_sign     <= r1_sign;
      r2_dz       <= r1_dz;
      r2_zero     <= r1_zero;
      r2_aneg     <= r1_aneg;
      r2_kq       <= w_l[19:15];
      r2_fq       <= w_l[14:0];
      r_out_valid <= r2_valid;
      r_q         <= w_q;
      r_dz        <= r2_dz;
    end
  end

endmodule

// File: tb/tb_alm_div_pipe.sv
// Scoreboard bench for alm_div_pipe: directed vectors, backpressure stream and mid-flight reset.
module tb_alm_div_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alm_div_pipe_if bus ();
  alm_div_pipe dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  typedef struct {
    logic [31:0] q;
    logic        dz;
    int          issue;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: retire results, check handshake rule and output hold under stall
  initial begin
    logic        hold;
    logic [31:0] hold_q;
    logic        hold_dz;
    exp_t        e;
    hold = 1'b0;
    hold_q = '0;
    hold_dz = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        n_cmp++;
        if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
          n_fail++;
          $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready,
                   (!bus.out_valid || bus.out_ready));
        end
        if (hold) begin
          n_cmp++;
          if (bus.out_valid !== 1'b1 || bus.q !== hold_q || bus.dz !== hold_dz) begin
            n_fail++;
            $display("FAIL hold cyc=%0d got v=%b q=%h dz=%b want v=1 q=%h dz=%b", cyc,
                     bus.out_valid, bus.q, bus.dz, hold_q, hold_dz);
          end
        end
        hold    = bus.out_valid && !bus.out_ready;
        hold_q  = bus.q;
        hold_dz = bus.dz;
        if (bus.out_valid && bus.out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result cyc=%0d got q=%h dz=%b want none", cyc, bus.q,
                     bus.dz);
          end else begin
            e = sb.pop_front();
            if (bus.q !== e.q || bus.dz !== e.dz) begin
              n_fail++;
              $display("FAIL result cyc=%0d got q=%h dz=%b want q=%h dz=%b", cyc, bus.q,
                       bus.dz, e.q, e.dz);
            end
            if (e.lat) begin
              n_cmp++;
              if (cyc - e.issue != 3) begin
                n_fail++;
                $display("FAIL latency got=%0d want=3", cyc - e.issue);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Offer one operand pair; enter at posedge+1, return at posedge+1 after acceptance
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] eq,
                       input logic edz, input bit lat);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.q = eq;
        e.dz = edz;
        e.issue = cyc;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL issue_timeout a=%h b=%h got=no_accept want=accept", a, b);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_q", bus.q, 32'd0);
    chk("rst_dz", {31'd0, bus.dz}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(16'd100, 16'd10, 32'h000A_8000, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    issue(16'd3, 16'd96, 32'h0000_0800, 1'b0, 1'b0);
    issue(16'd2, 16'd3, 32'h0000_C000, 1'b0, 1'b0);
    issue(16'd7, 16'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    issue(16'hFFF9, 16'd0, 32'h8000_0000, 1'b1, 1'b0);
    issue(16'd0, 16'd5, 32'h0000_0000, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 32'h0001_0000, 1'b0, 1'b0);
    issue(16'd32767, 16'd1, 32'h7FFF_0000, 1'b0, 1'b0);
    issue(16'd0, 16'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
`ifdef ALM_DIV_EXACT_ABS_EN
    issue(16'hFFA0, 16'd3, 32'hFFE0_0000, 1'b0, 1'b0);
    issue(16'h8000, 16'd1, 32'h8000_0000, 1'b0, 1'b0);
`else
    issue(16'hFFA0, 16'd3, 32'hFFE0_4000, 1'b0, 1'b0);
    issue(16'h8000, 16'd1, 32'h8001_0000, 1'b0, 1'b0);
`endif
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back stream with downstream stalled on cycles 4-8
    fork
      begin
        issue(16'd100, 16'd10, 32'h000A_8000, 1'b0, 1'b0);
        issue(16'd2, 16'd3, 32'h0000_C000, 1'b0, 1'b0);
        issue(16'd3, 16'd96, 32'h0000_0800, 1'b0, 1'b0);
        issue(16'd0, 16'd5, 32'h0000_0000, 1'b0, 1'b0);
        issue(16'd7, 16'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        issue(16'd1, 16'd1, 32'h0001_0000, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Three operations in flight, then a one-cycle reset must discard them all
    bus.out_ready = 1'b0;
    issue(16'd100, 16'd10, 32'h000A_8000, 1'b0, 1'b0);
    issue(16'd2, 16'd3, 32'h0000_C000, 1'b0, 1'b0);
    issue(16'd7, 16'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_q", bus.q, 32'd0);
    chk("flush_dz", {31'd0, bus.dz}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    issue(16'd2, 16'd3, 32'h0000_C000, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
